stopwatch_core: RTL

- Timekeeping stage directly downstream of the clock-divider block.
- Consumes the divider's outputs as single-cycle clock-enable pulses on the system clock: a 1 Hz count tick and a 2 Hz adjust tick. Never uses them as clocks.
- Maintains an MM:SS BCD stopwatch with pause and field-adjust modes.
- Drives four BCD digits to the downstream display multiplexer.

---
 rtl/stopwatch_core_pkg.sv | 25 ++
 rtl/stopwatch_core_if.sv | 27 ++
 rtl/stopwatch_core_bcd_mod_counter.sv | 33 +++
 rtl/stopwatch_core.sv | 70 +++++++
 4 files changed

// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_core_pkg;

    localparam int BCD_W = 4;

    typedef logic [2*BCD_W-1:0] bcd2_t;

    localparam bcd2_t SEC_LIMIT_BCD = 8'h59;
    localparam bcd2_t BCD_ZERO      = 8'h00;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_ADJUST = 1'b1
    } mode_e;

    // Elaboration-time conversion of a 0..99 integer to two BCD digits.
    function automatic bcd2_t toBcd2(input int unsigned value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(value / 10);
        ones = BCD_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control and display signals between the stopwatch core and its neighbours.
interface stopwatch_core_if;
    import stopwatch_core_pkg::*;

    logic             tick_1hz;
    logic             tick_2hz;
    logic             pause_pulse;
    logic             adj;
    logic             sel;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             running;
    logic             wrap;

    modport master (
        output tick_1hz, tick_2hz, pause_pulse, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, running, wrap
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause_pulse, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, running, wrap
    );

endinterface

// File: rtl/stopwatch_core_bcd_mod_counter.sv
// Two-digit BCD counter that rolls from `limit` back to 00 on increment.
module bcd_mod_counter
    import stopwatch_core_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  bcd2_t            limit,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             carry
);

    // Combinational so the next field can increment on the same edge.
    assign carry = inc && ({tens, ones} == limit);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            {tens, ones} <= BCD_ZERO;
        end else if (inc) begin
            if (carry) begin
                {tens, ones} <= BCD_ZERO;
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch driven by 1 Hz count and 2 Hz adjust clock enables.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int MIN_LIMIT     = 59,
    parameter bit START_RUNNING = 1'b1
) (
    input logic             clk,
    input logic             rst,
    stopwatch_core_if.slave bus
);

    localparam bcd2_t MinLimitBcd = toBcd2(MIN_LIMIT);

    mode_e mode;
    logic  countEn;
    logic  adjTick;
    logic  secInc;
    logic  minInc;
    logic  secCarry;
    logic  minCarry;
    logic  runningQ;
    logic  wrapQ;

    always_comb begin
        mode = bus.adj ? MODE_ADJUST : MODE_NORMAL;
    end

    // Count gating uses the pre-toggle running value when a pause lands on a tick.
    assign countEn = (mode == MODE_NORMAL) && bus.tick_1hz && runningQ;
    assign adjTick = (mode == MODE_ADJUST) && bus.tick_2hz;
    assign secInc  = countEn || (adjTick && bus.sel);
    assign minInc  = (countEn && secCarry) || (adjTick && !bus.sel);

    bcd_mod_counter u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (secInc),
        .limit (SEC_LIMIT_BCD),
        .tens  (bus.sec_tens),
        .ones  (bus.sec_ones),
        .carry (secCarry)
    );

    bcd_mod_counter u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (minInc),
        .limit (MinLimitBcd),
        .tens  (bus.min_tens),
        .ones  (bus.min_ones),
        .carry (minCarry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            runningQ <= START_RUNNING;
            wrapQ    <= 1'b0;
        end else begin
            if (bus.pause_pulse) begin
                runningQ <= ~runningQ;
            end
            wrapQ <= countEn && secCarry && minCarry;
        end
    end

    assign bus.running = runningQ;
    assign bus.wrap    = wrapQ;

endmodule
